// File: rtl/mantissa_align_pkg.sv
// Shared widths, FSM encoding and shift-step helper for the FP add/sub alignment stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mantissa_align_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 24;
    localparam int GRS_W   = 3;
    localparam int ALIGN_W = MANT_W + GRS_W;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits to shift this cycle: whatever is left, capped at the per-cycle step.
    function automatic logic [SHAMT_W-1:0] step_amount(input logic [SHAMT_W-1:0] cnt,
                                                       input int unsigned          step);
        logic [SHAMT_W-1:0] cap;
        cap = SHAMT_W'(step);
        return (cnt < cap) ? cnt : cap;
    endfunction

endpackage

// File: rtl/mantissa_align_if.sv
// Operand/result bundle between exponent comparator, alignment stage and mantissa adder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the input and the output side.
interface mantissa_align_if;
    import mantissa_align_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [EXP_W-1:0]   exp1;
    logic [EXP_W-1:0]   exp2;
    logic [MANT_W-1:0]  mant1;
    logic [MANT_W-1:0]  mant2;
    logic [SHAMT_W-1:0] nshift;
    logic               in1_ST_in2;
    logic               checktoobig;

    logic               out_valid;
    logic               out_ready;
    logic [MANT_W-1:0]  big_mant;
    logic [ALIGN_W-1:0] small_mant;
    logic [EXP_W-1:0]   exp_res;
    logic               swapped;

    // Producer/consumer side: drives operands and out_ready.
    modport master (
        output in_valid, exp1, exp2, mant1, mant2, nshift, in1_ST_in2, checktoobig, out_ready,
        input  in_ready, out_valid, big_mant, small_mant, exp_res, swapped
    );

    // Alignment stage side.
    modport slave (
        input  in_valid, exp1, exp2, mant1, mant2, nshift, in1_ST_in2, checktoobig, out_ready,
        output in_ready, out_valid, big_mant, small_mant, exp_res, swapped
    );

endinterface

// File: rtl/mantissa_align_sticky_shift_step.sv
// One right-shift step of the aligned field; every bit shifted out ORs into the sticky bit0.
// Latency: combinational.
// Backpressure: none.
module mantissa_align_sticky_shift_step
    import mantissa_align_pkg::*;
(
    input  logic [ALIGN_W-1:0] din_i,
    input  logic [SHAMT_W-1:0] amt_i,
    output logic [ALIGN_W-1:0] dout_o
);

    logic [ALIGN_W-1:0] shifted;
    logic [ALIGN_W-1:0] lost_mask;
    logic               lost;

    // Shift, then fold everything that fell off the bottom (and the old sticky) into bit0.
    always_comb begin
        shifted   = din_i >> amt_i;
        lost_mask = ~({ALIGN_W{1'b1}} << amt_i);
        lost      = |(din_i & lost_mask);
        dout_o    = {shifted[ALIGN_W-1:1], shifted[0] | lost | din_i[0]};
    end

endmodule

// File: rtl/mantissa_align.sv
// Swaps operands so the larger exponent is "big", then right-aligns the small mantissa with G/R/S.
// Latency: ceil(nshift/STEP) cycles after accept (next cycle for nshift==0 or checktoobig).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module mantissa_align
    import mantissa_align_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    mantissa_align_if.slave  bus
);

    state_t             state_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [SHAMT_W-1:0] cnt_d;
    logic [SHAMT_W-1:0] step_amt;
    logic [ALIGN_W-1:0] small_q;
    logic [ALIGN_W-1:0] small_d;
    logic [MANT_W-1:0]  big_q;
    logic [EXP_W-1:0]   exp_q;
    logic               swapped_q;
    logic               out_valid_q;

    logic [MANT_W-1:0]  big_sel;
    logic [MANT_W-1:0]  small_sel;
    logic [EXP_W-1:0]   exp_sel;

    // Operand swap: equal exponents (in1_ST_in2=0) keep operand 1 as big.
    always_comb begin
        big_sel   = bus.in1_ST_in2 ? bus.mant2 : bus.mant1;
        small_sel = bus.in1_ST_in2 ? bus.mant1 : bus.mant2;
        exp_sel   = bus.in1_ST_in2 ? bus.exp2  : bus.exp1;
    end

    // Per-cycle shift amount and remaining count.
    always_comb begin
        step_amt = step_amount(cnt_q, STEP);
        cnt_d    = cnt_q - step_amt;
    end

    mantissa_align_sticky_shift_step u_step (
        .din_i  (small_q),
        .amt_i  (step_amt),
        .dout_o (small_d)
    );

    // Control FSM plus operand/result registers; out_valid is registered with the DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            small_q     <= '0;
            big_q       <= '0;
            exp_q       <= '0;
            swapped_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        swapped_q <= bus.in1_ST_in2;
                        exp_q     <= exp_sel;
                        big_q     <= big_sel;
                        if (bus.checktoobig) begin
                            // Whole small operand lies below the sticky position.
                            small_q     <= {{(ALIGN_W-1){1'b0}}, |small_sel};
                            cnt_q       <= '0;
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            small_q <= {small_sel, {GRS_W{1'b0}}};
                            cnt_q   <= bus.nshift;
                            if (bus.nshift == '0) begin
                                state_q     <= DONE;
                                out_valid_q <= 1'b1;
                            end else begin
                                state_q <= SHIFT;
                            end
                        end
                    end
                end
                SHIFT: begin
                    small_q <= small_d;
                    cnt_q   <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.big_mant   = big_q;
    assign bus.small_mant = small_q;
    assign bus.exp_res    = exp_q;
    assign bus.swapped    = swapped_q;

endmodule

// File: tb/tb_mantissa_align.sv
// Directed bench for the alignment stage: hand-computed vectors, latency, hold and reset abort.
// Latency: n/a.
// Backpressure: exercises out_ready stall in DONE and in_valid while not ready.
module tb_mantissa_align;
    import mantissa_align_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;

    mantissa_align_if bus ();

    mantissa_align #(.STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operand bundle for exactly one accepting edge; returns #1 after that edge.
    task automatic send(input logic [7:0] e1, input logic [23:0] m1,
                        input logic [7:0] e2, input logic [23:0] m2,
                        input logic [4:0] ns, input logic st, input logic tb);
        @(negedge clk);
        bus.exp1        = e1;
        bus.mant1       = m1;
        bus.exp2        = e2;
        bus.mant2       = m2;
        bus.nshift      = ns;
        bus.in1_ST_in2  = st;
        bus.checktoobig = tb;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid shows, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic handoff(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_ovld_drop"}, {31'b0, bus.out_valid}, 32'h0);
        check({tag, "_irdy_back"}, {31'b0, bus.in_ready}, 32'h1);
    endtask

    task automatic check_result(input string tag, input int lat_exp,
                                input logic [23:0] big_exp, input logic [26:0] small_exp,
                                input logic [7:0] exp_exp, input logic sw_exp);
        wait_valid(cyc);
        check({tag, "_latency"}, cyc, lat_exp);
        check({tag, "_ovld"},  {31'b0, bus.out_valid}, 32'h1);
        check({tag, "_big"},   {8'b0, bus.big_mant}, {8'b0, big_exp});
        check({tag, "_small"}, {5'b0, bus.small_mant}, {5'b0, small_exp});
        check({tag, "_exp"},   {24'b0, bus.exp_res}, {24'b0, exp_exp});
        check({tag, "_swap"},  {31'b0, bus.swapped}, {31'b0, sw_exp});
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.exp1        = '0;
        bus.exp2        = '0;
        bus.mant1       = '0;
        bus.mant2       = '0;
        bus.nshift      = '0;
        bus.in1_ST_in2  = 1'b0;
        bus.checktoobig = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_irdy",  {31'b0, bus.in_ready}, 32'h1);
        check("rst_ovld",  {31'b0, bus.out_valid}, 32'h0);
        check("rst_small", {5'b0, bus.small_mant}, 32'h0);
        check("rst_big",   {8'b0, bus.big_mant}, 32'h0);
        check("rst_exp",   {24'b0, bus.exp_res}, 32'h0);
        check("rst_swap",  {31'b0, bus.swapped}, 32'h0);

        // 1: shift of 2 in one step
        send(8'd130, 24'h800000, 8'd128, 24'hC00000, 5'd2, 1'b0, 1'b0);
        check("t1_busy", {31'b0, bus.in_ready}, 32'h0);
        check_result("t1", 1, 24'h800000, 27'h1800000, 8'd130, 1'b0);
        handoff("t1");

        // 2: shift of 5 = 4+1, lost LSB becomes sticky
        send(8'd133, 24'h800000, 8'd128, 24'h800001, 5'd5, 1'b0, 1'b0);
        check_result("t2", 2, 24'h800000, 27'h0200001, 8'd133, 1'b0);
        handoff("t2");

        // 3: operand 2 larger, shift of 10 = 4+4+2
        send(8'd100, 24'hA00000, 8'd110, 24'h900000, 5'd10, 1'b1, 1'b0);
        check_result("t3", 3, 24'h900000, 27'h0014000, 8'd110, 1'b1);
        handoff("t3");

        // 4: checktoobig collapses small operand to sticky
        send(8'd200, 24'hFFFFFF, 8'd100, 24'h800000, 5'd0, 1'b0, 1'b1);
        check_result("t4", 0, 24'hFFFFFF, 27'h0000001, 8'd200, 1'b0);
        handoff("t4");

        // Equal exponents: operand 1 is big, no shift
        send(8'd127, 24'hC00000, 8'd127, 24'hA00000, 5'd0, 1'b0, 1'b0);
        check_result("teq", 0, 24'hC00000, 27'h5000000, 8'd127, 1'b0);
        handoff("teq");

        // Maximum legal shift: 24 -> 6 SHIFT cycles
        send(8'd150, 24'h800000, 8'd126, 24'h800000, 5'd24, 1'b0, 1'b0);
        check_result("t24", 6, 24'h800000, 27'h0000004, 8'd150, 1'b0);

        // 5: stall in DONE with in_valid pulsed; nothing may change
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.exp1        = 8'd10;
            bus.mant1       = 24'h123456;
            bus.exp2        = 8'd20;
            bus.mant2       = 24'hABCDEF;
            bus.nshift      = 5'd3;
            bus.in1_ST_in2  = 1'b1;
            bus.checktoobig = 1'b0;
            bus.in_valid    = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("t5_ovld",  {31'b0, bus.out_valid}, 32'h1);
            check("t5_irdy",  {31'b0, bus.in_ready}, 32'h0);
            check("t5_small", {5'b0, bus.small_mant}, 32'h0000004);
            check("t5_big",   {8'b0, bus.big_mant}, 32'h800000);
            check("t5_swap",  {31'b0, bus.swapped}, 32'h0);
        end
        // Handoff with in_valid still high: no same-edge accept
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("t5_hand_ovld", {31'b0, bus.out_valid}, 32'h0);
        check("t5_hand_irdy", {31'b0, bus.in_ready}, 32'h1);
        check("t5_hold_small", {5'b0, bus.small_mant}, 32'h0000004);
        check("t5_hold_exp",   {24'b0, bus.exp_res}, 32'd150);
        bus.in_valid = 1'b0;
        // That late in_valid was accepted on the following edge only if still high; it was dropped
        // before that edge, so the stage must remain idle.
        @(posedge clk);
        #1;
        check("t5_no_accept", {31'b0, bus.in_ready}, 32'h1);

        // 6: reset during SHIFT aborts the operation
        send(8'd150, 24'h800000, 8'd130, 24'hFFFFFF, 5'd20, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("t6_midshift", {31'b0, bus.out_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ovld",  {31'b0, bus.out_valid}, 32'h0);
        check("t6_small", {5'b0, bus.small_mant}, 32'h0);
        check("t6_big",   {8'b0, bus.big_mant}, 32'h0);
        check("t6_exp",   {24'b0, bus.exp_res}, 32'h0);
        check("t6_irdy",  {31'b0, bus.in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Recovery after abort
        send(8'd130, 24'h800000, 8'd128, 24'hC00000, 5'd2, 1'b0, 1'b0);
        check_result("trec", 1, 24'h800000, 27'h1800000, 8'd130, 1'b0);
        handoff("trec");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
